hazard_unit: RTL and testbench



---
 rtl/hazard_unit.sv | 156 +++++++++++++++
 tb/tb_hazard_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard unit: operand forwarding, load-use stalls, memory wait, debug step, branch flush
module hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter bit BR_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              debug_en_i,
    input  logic              debug_step_i,
    input  logic              rs_used_i,
    input  logic              rt_used_i,
    input  logic              is_store_id_i,
    input  logic [REG_AW-1:0] addr_rs_i,
    input  logic [REG_AW-1:0] addr_rt_i,
    input  logic [REG_AW-1:0] regw_addr_exe_i,
    input  logic [REG_AW-1:0] regw_addr_mem_i,
    input  logic [REG_AW-1:0] regw_addr_wb_i,
    input  logic              wb_wen_exe_i,
    input  logic              wb_wen_mem_i,
    input  logic              wb_wen_wb_i,
    input  logic              is_load_exe_i,
    input  logic              is_load_wb_i,
    input  logic              is_store_mem_i,
    input  logic [REG_AW-1:0] addr_rt_mem_i,
    input  logic              branch_taken_i,
    input  logic              mem_busy_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              fwd_m_o,
    output logic              if_en_o,
    output logic              id_en_o,
    output logic              exe_en_o,
    output logic              mem_en_o,
    output logic              wb_en_o,
    output logic              if_rst_o,
    output logic              id_rst_o,
    output logic              exe_rst_o,
    output logic              mem_rst_o,
    output logic              wb_rst_o,
    output logic              stalled_o
);

    localparam int CW = 3;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LSTALL,
        ST_MWAIT,
        ST_DHOLD
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            step_prev_q;
    logic            step_pulse;
    logic            load_use;
    logic [4:0]      en;
    logic [4:0]      clr;
    logic            stall;

    function automatic logic [1:0] fwd_sel(
        input logic              used,
        input logic [REG_AW-1:0] addr,
        input logic              wen_exe,
        input logic [REG_AW-1:0] a_exe,
        input logic              wen_mem,
        input logic [REG_AW-1:0] a_mem,
        input logic              wen_wb,
        input logic [REG_AW-1:0] a_wb
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (used && addr != '0) begin
            if (wen_exe && a_exe == addr)      sel = 2'd1;
            else if (wen_mem && a_mem == addr) sel = 2'd2;
            else if (wen_wb && a_wb == addr)   sel = 2'd3;
        end
        return sel;
    endfunction

    assign fwd_a_o = fwd_sel(rs_used_i, addr_rs_i, wb_wen_exe_i, regw_addr_exe_i,
                             wb_wen_mem_i, regw_addr_mem_i, wb_wen_wb_i, regw_addr_wb_i);
    assign fwd_b_o = fwd_sel(rt_used_i, addr_rt_i, wb_wen_exe_i, regw_addr_exe_i,
                             wb_wen_mem_i, regw_addr_mem_i, wb_wen_wb_i, regw_addr_wb_i);

    assign fwd_m_o = is_store_mem_i && is_load_wb_i && wb_wen_wb_i &&
                     addr_rt_mem_i != '0 && regw_addr_wb_i == addr_rt_mem_i;

    // A store reading the loaded value only as rt gets it later through fwd_m, so it need not stall.
    assign load_use = is_load_exe_i && wb_wen_exe_i && regw_addr_exe_i != '0 &&
                      ((rs_used_i && addr_rs_i == regw_addr_exe_i) ||
                       (rt_used_i && addr_rt_i == regw_addr_exe_i && !is_store_id_i));

    assign step_pulse = debug_step_i && !step_prev_q;

    // Outputs are decoded in the same cycle as the hazard so the bubble lands on the offending instruction.
    // A nonzero counter means a load stall is in progress; it survives MWAIT/DHOLD so stalls resume intact.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en      = 5'b11111;
        clr     = 5'b00000;
        stall   = 1'b0;
        if (mem_busy_i) begin
            en      = 5'b00000;
            stall   = 1'b1;
            state_d = ST_MWAIT;
        end else if (debug_en_i && !step_pulse) begin
            en      = 5'b00000;
            stall   = 1'b1;
            state_d = ST_DHOLD;
        end else if (cnt_q != '0) begin
            en      = 5'b00111;
            clr     = 5'b00100;
            stall   = 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == CW'(1)) ? ST_RUN : ST_LSTALL;
        end else if (load_use) begin
            en    = 5'b00111;
            clr   = 5'b00100;
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
                cnt_d   = CW'(LOAD_LAT - 1);
                state_d = ST_LSTALL;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = ST_RUN;
            if (BR_FLUSH && branch_taken_i) clr = 5'b01000;
        end
        if (!rst_n) begin
            en    = 5'b11111;
            clr   = 5'b11111;
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_prev_q <= debug_step_i;
        end
    end

    assign {if_en_o, id_en_o, exe_en_o, mem_en_o, wb_en_o}      = en;
    assign {if_rst_o, id_rst_o, exe_rst_o, mem_rst_o, wb_rst_o} = clr;
    assign stalled_o = stall;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit (LOAD_LAT=1/BR_FLUSH=1 and LOAD_LAT=3/BR_FLUSH=0)
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       debug_en, debug_step, rs_used, rt_used, is_store_id;
    logic [4:0] addr_rs, addr_rt, regw_exe, regw_mem, regw_wb, addr_rt_mem;
    logic       wen_exe, wen_mem, wen_wb, is_load_exe, is_load_wb, is_store_mem;
    logic       branch_taken, mem_busy;

    logic [1:0] fa1, fb1, fa3, fb3;
    logic       fm1, fm3, st1, st3;
    logic [4:0] en1, rs1, en3, rs3;

    typedef struct {
        string       name;
        logic [15:0] e1;
        logic [15:0] e3;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [10:0] NRM = {5'b11111, 5'b00000, 1'b0};
    localparam logic [10:0] STL = {5'b00111, 5'b00100, 1'b1};
    localparam logic [10:0] HLD = {5'b00000, 5'b00000, 1'b1};
    localparam logic [10:0] FLS = {5'b11111, 5'b01000, 1'b0};

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(5), .LOAD_LAT(1), .BR_FLUSH(1'b1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .debug_en_i(debug_en), .debug_step_i(debug_step),
        .rs_used_i(rs_used), .rt_used_i(rt_used), .is_store_id_i(is_store_id),
        .addr_rs_i(addr_rs), .addr_rt_i(addr_rt),
        .regw_addr_exe_i(regw_exe), .regw_addr_mem_i(regw_mem), .regw_addr_wb_i(regw_wb),
        .wb_wen_exe_i(wen_exe), .wb_wen_mem_i(wen_mem), .wb_wen_wb_i(wen_wb),
        .is_load_exe_i(is_load_exe), .is_load_wb_i(is_load_wb), .is_store_mem_i(is_store_mem),
        .addr_rt_mem_i(addr_rt_mem), .branch_taken_i(branch_taken), .mem_busy_i(mem_busy),
        .fwd_a_o(fa1), .fwd_b_o(fb1), .fwd_m_o(fm1),
        .if_en_o(en1[4]), .id_en_o(en1[3]), .exe_en_o(en1[2]), .mem_en_o(en1[1]), .wb_en_o(en1[0]),
        .if_rst_o(rs1[4]), .id_rst_o(rs1[3]), .exe_rst_o(rs1[2]), .mem_rst_o(rs1[1]), .wb_rst_o(rs1[0]),
        .stalled_o(st1)
    );

    hazard_unit #(.REG_AW(5), .LOAD_LAT(3), .BR_FLUSH(1'b0)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .debug_en_i(debug_en), .debug_step_i(debug_step),
        .rs_used_i(rs_used), .rt_used_i(rt_used), .is_store_id_i(is_store_id),
        .addr_rs_i(addr_rs), .addr_rt_i(addr_rt),
        .regw_addr_exe_i(regw_exe), .regw_addr_mem_i(regw_mem), .regw_addr_wb_i(regw_wb),
        .wb_wen_exe_i(wen_exe), .wb_wen_mem_i(wen_mem), .wb_wen_wb_i(wen_wb),
        .is_load_exe_i(is_load_exe), .is_load_wb_i(is_load_wb), .is_store_mem_i(is_store_mem),
        .addr_rt_mem_i(addr_rt_mem), .branch_taken_i(branch_taken), .mem_busy_i(mem_busy),
        .fwd_a_o(fa3), .fwd_b_o(fb3), .fwd_m_o(fm3),
        .if_en_o(en3[4]), .id_en_o(en3[3]), .exe_en_o(en3[2]), .mem_en_o(en3[1]), .wb_en_o(en3[0]),
        .if_rst_o(rs3[4]), .id_rst_o(rs3[3]), .exe_rst_o(rs3[2]), .mem_rst_o(rs3[1]), .wb_rst_o(rs3[0]),
        .stalled_o(st3)
    );

    function automatic logic [15:0] obs1();
        return {en1, rs1, st1, fa1, fb1, fm1};
    endfunction

    function automatic logic [15:0] obs3();
        return {en3, rs3, st3, fa3, fb3, fm3};
    endfunction

    function automatic logic [15:0] mk(input logic [10:0] ctl, input logic [1:0] fa,
                                       input logic [1:0] fb, input logic fm);
        return {ctl, fa, fb, fm};
    endfunction

    task automatic clr_in();
        debug_en = 0; debug_step = 0; rs_used = 0; rt_used = 0; is_store_id = 0;
        addr_rs = 0; addr_rt = 0; regw_exe = 0; regw_mem = 0; regw_wb = 0; addr_rt_mem = 0;
        wen_exe = 0; wen_mem = 0; wen_wb = 0; is_load_exe = 0; is_load_wb = 0; is_store_mem = 0;
        branch_taken = 0; mem_busy = 0;
    endtask

    task automatic ld_hazard(input logic [4:0] r);
        is_load_exe = 1; wen_exe = 1; regw_exe = r; rs_used = 1; addr_rs = r;
    endtask

    task automatic test_reset();
        exp_t x;
        clr_in();
        rst_n = 0;
        wen_exe = 1; regw_exe = 5'd3; rs_used = 1; addr_rs = 5'd3;
        x.name = "reset"; x.e1 = {5'b0, 5'b11111, 1'b0, 2'd1, 2'd0, 1'b0}; x.e3 = x.e1;
        sb.push_back(x);
        #3;
        x = sb.pop_front();
        vectors++;
        if ((obs1() & 16'h07FF) !== x.e1) begin
            miscompares++; $display("FAIL %s lat1: got %h exp %h", x.name, obs1() & 16'h07FF, x.e1);
        end
        vectors++;
        if ((obs3() & 16'h07FF) !== x.e3) begin
            miscompares++; $display("FAIL %s lat3: got %h exp %h", x.name, obs3() & 16'h07FF, x.e3);
        end
        @(posedge clk); #1;
        rst_n = 1;
        clr_in();
    endtask

    task automatic test_forwarding();
        exp_t x;
        for (int i = 0; i < 5; i++) begin
            clr_in();
            case (i)
                0: begin wen_exe = 1; regw_exe = 4; wen_mem = 1; regw_mem = 4;
                         rs_used = 1; rt_used = 1; addr_rs = 4; addr_rt = 4;
                         x.e1 = mk(NRM, 2'd1, 2'd1, 1'b0); end
                1: begin wen_mem = 1; regw_mem = 4; wen_wb = 1; regw_wb = 4;
                         rs_used = 1; rt_used = 1; addr_rs = 4; addr_rt = 4;
                         x.e1 = mk(NRM, 2'd2, 2'd2, 1'b0); end
                2: begin wen_wb = 1; regw_wb = 4; rs_used = 1; addr_rs = 4; addr_rt = 4;
                         x.e1 = mk(NRM, 2'd3, 2'd0, 1'b0); end
                3: begin is_load_exe = 1; wen_exe = 1; wen_mem = 1; wen_wb = 1;
                         rs_used = 1; rt_used = 1;
                         x.e1 = mk(NRM, 2'd0, 2'd0, 1'b0); end
                default: begin regw_exe = 4; wen_mem = 1; regw_mem = 7;
                         rs_used = 1; rt_used = 1; addr_rs = 4; addr_rt = 7;
                         x.e1 = mk(NRM, 2'd0, 2'd2, 1'b0); end
            endcase
            x.name = "fwd"; x.e3 = x.e1;
            sb.push_back(x);
            @(negedge clk);
            x = sb.pop_front();
            vectors++;
            if (obs1() !== x.e1) begin miscompares++; $display("FAIL %s[%0d] lat1: got %h exp %h", x.name, i, obs1(), x.e1); end
            vectors++;
            if (obs3() !== x.e3) begin miscompares++; $display("FAIL %s[%0d] lat3: got %h exp %h", x.name, i, obs3(), x.e3); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fwd_m();
        exp_t x;
        for (int i = 0; i < 6; i++) begin
            clr_in();
            case (i)
                0: begin is_load_exe = 1; wen_exe = 1; regw_exe = 5; is_store_id = 1;
                         rs_used = 1; addr_rs = 1; rt_used = 1; addr_rt = 5;
                         x.e1 = mk(NRM, 2'd0, 2'd1, 1'b0); x.e3 = x.e1; end
                1: begin is_store_mem = 1; addr_rt_mem = 5; is_load_wb = 1; wen_wb = 1; regw_wb = 5;
                         x.e1 = mk(NRM, 2'd0, 2'd0, 1'b1); x.e3 = x.e1; end
                2: begin is_store_mem = 1; is_load_wb = 1; wen_wb = 1;
                         x.e1 = mk(NRM, 2'd0, 2'd0, 1'b0); x.e3 = x.e1; end
                3: begin is_load_exe = 1; wen_exe = 1; regw_exe = 5; is_store_id = 1;
                         rs_used = 1; addr_rs = 5; rt_used = 1; addr_rt = 5;
                         x.e1 = mk(STL, 2'd1, 2'd1, 1'b0); x.e3 = x.e1; end
                4: begin x.e1 = mk(NRM, 2'd0, 2'd0, 1'b0); x.e3 = mk(STL, 2'd0, 2'd0, 1'b0); end
                default: begin x.e1 = mk(NRM, 2'd0, 2'd0, 1'b0); x.e3 = mk(STL, 2'd0, 2'd0, 1'b0); end
            endcase
            x.name = "fwd_m";
            sb.push_back(x);
            @(negedge clk);
            x = sb.pop_front();
            vectors++;
            if (obs1() !== x.e1) begin miscompares++; $display("FAIL %s[%0d] lat1: got %h exp %h", x.name, i, obs1(), x.e1); end
            vectors++;
            if (obs3() !== x.e3) begin miscompares++; $display("FAIL %s[%0d] lat3: got %h exp %h", x.name, i, obs3(), x.e3); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t x;
        for (int i = 0; i < 4; i++) begin
            clr_in();
            case (i)
                0: begin ld_hazard(5'd3);
                         x.e1 = mk(STL, 2'd1, 2'd0, 1'b0); x.e3 = x.e1; end
                1: begin rs_used = 1; addr_rs = 3; wen_mem = 1; regw_mem = 3;
                         x.e1 = mk(NRM, 2'd2, 2'd0, 1'b0); x.e3 = mk(STL, 2'd2, 2'd0, 1'b0); end
                2: begin rs_used = 1; addr_rs = 3; wen_wb = 1; regw_wb = 3;
                         x.e1 = mk(NRM, 2'd3, 2'd0, 1'b0); x.e3 = mk(STL, 2'd3, 2'd0, 1'b0); end
                default: begin x.e1 = mk(NRM, 2'd0, 2'd0, 1'b0); x.e3 = x.e1; end
            endcase
            x.name = "load_use";
            sb.push_back(x);
            @(negedge clk);
            x = sb.pop_front();
            vectors++;
            if (obs1() !== x.e1) begin miscompares++; $display("FAIL %s[%0d] lat1: got %h exp %h", x.name, i, obs1(), x.e1); end
            vectors++;
            if (obs3() !== x.e3) begin miscompares++; $display("FAIL %s[%0d] lat3: got %h exp %h", x.name, i, obs3(), x.e3); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_busy();
        exp_t x;
        for (int i = 0; i < 6; i++) begin
            clr_in();
            x.e1 = mk(NRM, 2'd0, 2'd0, 1'b0); x.e3 = x.e1;
            case (i)
                0: begin ld_hazard(5'd3); x.e1 = mk(STL, 2'd1, 2'd0, 1'b0); x.e3 = x.e1; end
                1, 2: begin mem_busy = 1; x.e1 = mk(HLD, 2'd0, 2'd0, 1'b0); x.e3 = x.e1; end
                3, 4: x.e3 = mk(STL, 2'd0, 2'd0, 1'b0);
                default: ;
            endcase
            x.name = "mem_busy";
            sb.push_back(x);
            @(negedge clk);
            x = sb.pop_front();
            vectors++;
            if (obs1() !== x.e1) begin miscompares++; $display("FAIL %s[%0d] lat1: got %h exp %h", x.name, i, obs1(), x.e1); end
            vectors++;
            if (obs3() !== x.e3) begin miscompares++; $display("FAIL %s[%0d] lat3: got %h exp %h", x.name, i, obs3(), x.e3); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t x;
        for (int i = 0; i < 4; i++) begin
            clr_in();
            x.e1 = mk(NRM, 2'd0, 2'd0, 1'b0); x.e3 = x.e1;
            case (i)
                0: begin ld_hazard(5'd6); x.e1 = mk(STL, 2'd1, 2'd0, 1'b0); x.e3 = x.e1; end
                1: x.e3 = mk(STL, 2'd0, 2'd0, 1'b0);
                2: begin rst_n = 0; x.e1 = {5'b11111, 5'b11111, 1'b0, 5'b0}; x.e3 = x.e1; end
                default: ;
            endcase
            x.name = "rst_mid";
            sb.push_back(x);
            @(negedge clk);
            x = sb.pop_front();
            vectors++;
            if (obs1() !== x.e1) begin miscompares++; $display("FAIL %s[%0d] lat1: got %h exp %h", x.name, i, obs1(), x.e1); end
            vectors++;
            if (obs3() !== x.e3) begin miscompares++; $display("FAIL %s[%0d] lat3: got %h exp %h", x.name, i, obs3(), x.e3); end
            @(posedge clk); #1;
            rst_n = 1;
        end
    endtask

    task automatic test_debug();
        exp_t x;
        for (int i = 0; i < 11; i++) begin
            clr_in();
            debug_en = 1;
            x.e1 = mk(HLD, 2'd0, 2'd0, 1'b0); x.e3 = x.e1;
            case (i)
                0, 3: begin debug_step = 1; x.e1 = mk(NRM, 2'd0, 2'd0, 1'b0); x.e3 = x.e1; end
                1, 7: debug_step = 1;
                2:    debug_step = 0;
                4: begin debug_step = 1; ld_hazard(5'd2); x.e1 = mk(HLD, 2'd1, 2'd0, 1'b0); x.e3 = x.e1; end
                5: begin ld_hazard(5'd2); x.e1 = mk(HLD, 2'd1, 2'd0, 1'b0); x.e3 = x.e1; end
                6: begin debug_step = 1; ld_hazard(5'd2); x.e1 = mk(STL, 2'd1, 2'd0, 1'b0); x.e3 = x.e1; end
                8, 9: begin debug_en = 0; x.e1 = mk(NRM, 2'd0, 2'd0, 1'b0); x.e3 = mk(STL, 2'd0, 2'd0, 1'b0); end
                default: begin debug_en = 0; x.e1 = mk(NRM, 2'd0, 2'd0, 1'b0); x.e3 = x.e1; end
            endcase
            x.name = "debug";
            sb.push_back(x);
            @(negedge clk);
            x = sb.pop_front();
            vectors++;
            if (obs1() !== x.e1) begin miscompares++; $display("FAIL %s[%0d] lat1: got %h exp %h", x.name, i, obs1(), x.e1); end
            vectors++;
            if (obs3() !== x.e3) begin miscompares++; $display("FAIL %s[%0d] lat3: got %h exp %h", x.name, i, obs3(), x.e3); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        exp_t x;
        for (int i = 0; i < 7; i++) begin
            clr_in();
            branch_taken = 1;
            x.e1 = mk(FLS, 2'd0, 2'd0, 1'b0); x.e3 = mk(NRM, 2'd0, 2'd0, 1'b0);
            case (i)
                1: begin ld_hazard(5'd9); x.e1 = mk(STL, 2'd1, 2'd0, 1'b0); x.e3 = x.e1; end
                2, 3: x.e3 = mk(STL, 2'd0, 2'd0, 1'b0);
                5: begin mem_busy = 1; x.e1 = mk(HLD, 2'd0, 2'd0, 1'b0); x.e3 = x.e1; end
                6: begin branch_taken = 0; x.e1 = mk(NRM, 2'd0, 2'd0, 1'b0); end
                default: ;
            endcase
            x.name = "branch";
            sb.push_back(x);
            @(negedge clk);
            x = sb.pop_front();
            vectors++;
            if (obs1() !== x.e1) begin miscompares++; $display("FAIL %s[%0d] lat1: got %h exp %h", x.name, i, obs1(), x.e1); end
            vectors++;
            if (obs3() !== x.e3) begin miscompares++; $display("FAIL %s[%0d] lat3: got %h exp %h", x.name, i, obs3(), x.e3); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_fwd_m();
        test_load_use();
        test_mem_busy();
        test_reset_mid_stall();
        test_debug();
        test_branch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
